// File: rtl/seq_scan_arbiter_pkg.sv
// Shared definitions for the sequence-scan arbiter.
// Contents:
//   state_t          - FSM encoding (IDLE -> SHIFT -> REPORT -> IDLE)
//   DEFAULT_PATTERN  - pattern loaded at reset (LSBs used, zero-extended)
//   match_w()        - width of the per-frame match counter
//   default_pattern()- DEFAULT_PATTERN trimmed/zero-extended to a pattern length
package seq_scan_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

  // At most FRAME_LEN-PAT_LEN+1 matches fit in one frame, so this width can
  // never overflow.
  function automatic int match_w(input int frame_len, input int pat_len);
    return $clog2(frame_len - pat_len + 2);
  endfunction

  // Keep only the pat_len LSBs of DEFAULT_PATTERN; upper bits read as zero.
  function automatic logic [31:0] default_pattern(input int pat_len);
    logic [31:0] p;
    p = 32'(DEFAULT_PATTERN);
    for (int i = 0; i < 32; i++) begin
      if (i >= pat_len) p[i] = 1'b0;
    end
    return p;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern detector with overlapping-match counter.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clear       - start of a new frame: drop history and zero the count
//   bitValid    - bitIn carries a frame bit this cycle
//   bitIn       - serial frame bit (MSB of the frame first)
//   pattern     - active pattern, MSB = oldest bit
//   matchCount  - running match total INCLUDING the bit presented this cycle,
//                 so the owner can capture the final total on the edge that
//                 shifts in the last bit
module seq_match_core
  import seq_scan_arbiter_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int PAT_LEN   = 4,
  localparam int MATCH_W  = match_w(FRAME_LEN, PAT_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               bitValid,
  input  logic               bitIn,
  input  logic [PAT_LEN-1:0] pattern,
  output logic [MATCH_W-1:0] matchCount
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] hist_q;
  logic [FILL_W-1:0]  fill_q;
  logic [MATCH_W-1:0] count_q;

  logic [PAT_LEN:0]   shifted;
  logic [PAT_LEN-1:0] hist_d;
  logic [FILL_W-1:0]  fill_d;
  logic               hit;

  // fill counts bits seen this frame, saturating at PAT_LEN; a window only
  // counts once it is made entirely of bits from the current frame.
  always_comb begin
    shifted = {hist_q, bitIn};
    hist_d  = shifted[PAT_LEN-1:0];
    fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    hit     = bitValid && (fill_d == FILL_FULL) && (hist_d == pattern);
  end

  assign matchCount = count_q + MATCH_W'(hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      hist_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
    end else if (bitValid) begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      count_q <= matchCount;
    end
  end

endmodule

// File: rtl/seq_scan_arbiter.sv
// Round-robin frame arbiter feeding a serial pattern detector.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   req         - per-channel frame request (level)
//   frameData   - channel c frame at [c*FRAME_LEN +: FRAME_LEN], MSB first
//   cfgWe       - pattern write strobe (accepted only in IDLE)
//   cfgPattern  - new pattern, MSB = oldest bit
//   gnt         - one-hot grant, high for the first SHIFT cycle only
//   busy        - high in SHIFT and REPORT
//   done        - one-cycle completion pulse
//   doneId      - channel of the last completed frame (held until next done)
//   matchCount  - matches in that frame (held until next done)
//   cfgErr      - one-cycle pulse for a pattern write rejected while busy
// Handshake: done is a valid-only strobe (no ready); doneId/matchCount are
// valid in the done cycle and stay stable until the next done.
module seq_scan_arbiter
  import seq_scan_arbiter_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int FRAME_LEN = 16,
  parameter int PAT_LEN   = 4,
  localparam int ID_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int MATCH_W  = match_w(FRAME_LEN, PAT_LEN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           req,
  input  logic [NUM_CH*FRAME_LEN-1:0] frameData,
  input  logic                        cfgWe,
  input  logic [PAT_LEN-1:0]          cfgPattern,
  output logic [NUM_CH-1:0]           gnt,
  output logic                        busy,
  output logic                        done,
  output logic [ID_W-1:0]             doneId,
  output logic [MATCH_W-1:0]          matchCount,
  output logic                        cfgErr
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0]   LAST_BIT    = CNT_W'(FRAME_LEN - 1);
  localparam logic [31:0]        RESET_PAT32 = default_pattern(PAT_LEN);
  localparam logic [PAT_LEN-1:0] RESET_PAT   = RESET_PAT32[PAT_LEN-1:0];
  // Pointer at the last channel makes channel 0 the first candidate.
  localparam logic [ID_W-1:0]    LAST_CH     = ID_W'(NUM_CH - 1);

  state_t               state_q;
  logic [ID_W-1:0]      last_q;
  logic [ID_W-1:0]      cur_q;
  logic [FRAME_LEN-1:0] frame_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [PAT_LEN-1:0]   pattern_q;

  logic                 win_found;
  logic [ID_W-1:0]      win_id;
  logic [ID_W-1:0]      cand;
  int                   idx;
  logic                 grant;
  logic [MATCH_W-1:0]   core_count;

  // Scan channels starting one after the last granted channel.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = idx[ID_W-1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign grant = (state_q == ST_IDLE) && win_found;

  seq_match_core #(
    .FRAME_LEN (FRAME_LEN),
    .PAT_LEN   (PAT_LEN)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (grant),
    .bitValid   (state_q == ST_SHIFT),
    .bitIn      (frame_q[FRAME_LEN-1]),
    .pattern    (pattern_q),
    .matchCount (core_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= LAST_CH;
      cur_q      <= '0;
      frame_q    <= '0;
      cnt_q      <= '0;
      pattern_q  <= RESET_PAT;
      gnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      doneId     <= '0;
      matchCount <= '0;
      cfgErr     <= 1'b0;
    end else begin
      gnt    <= '0;
      done   <= 1'b0;
      cfgErr <= 1'b0;

      // A write on the grant edge lands before the first compare of the frame.
      if (cfgWe) begin
        if (state_q == ST_IDLE) pattern_q <= cfgPattern;
        else                    cfgErr    <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            state_q <= ST_SHIFT;
            busy    <= 1'b1;
            gnt     <= NUM_CH'(1) << win_id;
            last_q  <= win_id;
            cur_q   <= win_id;
            frame_q <= frameData[win_id*FRAME_LEN +: FRAME_LEN];
            cnt_q   <= '0;
          end
        end
        ST_SHIFT: begin
          frame_q <= frame_q << 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            // core_count already includes the bit shifted on this edge.
            state_q    <= ST_REPORT;
            done       <= 1'b1;
            doneId     <= cur_q;
            matchCount <= core_count;
          end
        end
        ST_REPORT: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_arbiter.sv
module tb_seq_scan_arbiter;

  localparam int NCH = 4;
  localparam int FL  = 16;
  localparam int PL  = 4;
  localparam int IW  = 2;
  localparam int MW  = 4;
  localparam int W   = IW + MW;

  // ---------------- clock / reset / signals ----------------
  logic            clk;
  logic            rst_n;
  logic [NCH-1:0]  req;
  logic [NCH*FL-1:0] frameData;
  logic            cfgWe;
  logic [PL-1:0]   cfgPattern;
  logic [NCH-1:0]  gnt;
  logic            busy;
  logic            done;
  logic [IW-1:0]   doneId;
  logic [MW-1:0]   matchCount;
  logic            cfgErr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_scan_arbiter #(
    .NUM_CH    (NCH),
    .FRAME_LEN (FL),
    .PAT_LEN   (PL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .frameData  (frameData),
    .cfgWe      (cfgWe),
    .cfgPattern (cfgPattern),
    .gnt        (gnt),
    .busy       (busy),
    .done       (done),
    .doneId     (doneId),
    .matchCount (matchCount),
    .cfgErr     (cfgErr)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_e;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected frame result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected_done: doneId=%0d matchCount=%0d with nothing expected", doneId, matchCount);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_done_id", 32'(doneId), 32'(sb_e[W-1:MW]));
        check("sb_match_count", 32'(matchCount), 32'(sb_e[MW-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    cfgWe = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic cfg_idle(input logic [PL-1:0] pat);
    wait_idle();
    cfgWe      = 1'b1;
    cfgPattern = pat;
    @(posedge clk); #1;
    cfgWe = 1'b0;
    check("cfg_err_idle", 32'(cfgErr), 32'd0);
  endtask

  // cfg_mode: 0 none, 1 write on the grant edge, 2 write during SHIFT cycle cfg_cycle
  task automatic run_frame(input int ch, input logic [FL-1:0] data, input int exp_cnt,
                           input int cfg_mode, input logic [PL-1:0] cfg_pat, input int cfg_cycle);
    int lat;
    bit seen;
    wait_idle();
    frameData = {NCH{16'h5A5A}};
    frameData[ch*FL +: FL] = data;
    req = 4'b0001 << ch;
    if (cfg_mode == 1) begin
      cfgWe      = 1'b1;
      cfgPattern = cfg_pat;
    end
    exp_q.push_back({IW'(ch), MW'(exp_cnt)});
    @(posedge clk); #1;
    req       = '0;
    cfgWe     = 1'b0;
    frameData = ~frameData;  // later changes must not reach the frame
    check("gnt_onehot", 32'(gnt), 32'(4'b0001 << ch));
    check("busy_in_shift", 32'(busy), 32'd1);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (cfg_mode == 2 && lat == cfg_cycle) begin
        cfgWe      = 1'b1;
        cfgPattern = cfg_pat;
      end
      @(posedge clk); #1;
      lat++;
      if (lat == 2) check("gnt_one_cycle", 32'(gnt), 32'd0);
      if (cfg_mode == 2 && lat == cfg_cycle + 1) begin
        cfgWe = 1'b0;
        check("cfg_err_pulse", 32'(cfgErr), 32'd1);
      end
      if (cfg_mode == 2 && lat == cfg_cycle + 2) check("cfg_err_one_cycle", 32'(cfgErr), 32'd0);
      if (done) seen = 1'b1;
    end
    check("done_latency", 32'(lat), 32'd17);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("done_pulse_width", 32'(done), 32'd0);
    check("done_id_hold", 32'(doneId), 32'(ch));
    check("count_hold", 32'(matchCount), 32'(exp_cnt));
  endtask

  // ---------------- stimulus ----------------
  logic [NCH-1:0] rr_ord [4];

  initial begin
    int g;
    logic prev_busy;
    rst_n      = 1'b0;
    req        = '0;
    frameData  = '0;
    cfgWe      = 1'b0;
    cfgPattern = '0;
    #23;
    do_reset();

    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_id", 32'(doneId), 32'd0);
    check("rst_match_count", 32'(matchCount), 32'd0);
    check("rst_cfg_err", 32'(cfgErr), 32'd0);

    // Default pattern 1011
    run_frame(1, 16'hB0B0, 2, 0, 4'b0000, 0);
    run_frame(0, 16'hB6C0, 3, 0, 4'b0000, 0);   // overlapping matches
    run_frame(3, 16'h0000, 0, 0, 4'b0000, 0);
    // Rejected write mid-frame; pattern must stay 1011
    run_frame(1, 16'hB0B0, 2, 2, 4'b0110, 5);
    run_frame(2, 16'h000B, 1, 0, 4'b0000, 0);   // 0110 would give 0 here
    // Accepted write in IDLE
    cfg_idle(4'b0110);
    run_frame(1, 16'h6666, 4, 0, 4'b0000, 0);
    // Write on the grant edge applies to that frame (0110 would give 0)
    run_frame(0, 16'h000B, 1, 1, 4'b1011, 0);

    // Round-robin with req held on ch0 and ch2
    do_reset();
    frameData = {NCH{16'hFFFF}};
    frameData[0*FL +: FL] = 16'hB6C0;
    frameData[2*FL +: FL] = 16'h0000;
    rr_ord[0] = 4'b0001;
    rr_ord[1] = 4'b0100;
    rr_ord[2] = 4'b0001;
    rr_ord[3] = 4'b0100;
    exp_q.push_back({IW'(0), MW'(3)});
    exp_q.push_back({IW'(2), MW'(0)});
    exp_q.push_back({IW'(0), MW'(3)});
    exp_q.push_back({IW'(2), MW'(0)});
    req       = 4'b0101;
    g         = 0;
    prev_busy = busy;
    for (int cyc = 0; cyc < 200 && g < 4; cyc++) begin
      @(posedge clk); #1;
      if (gnt != '0) begin
        check("rr_order", 32'(gnt), 32'(rr_ord[g]));
        check("rr_idle_before_grant", 32'(prev_busy), 32'd0);
        g++;
        if (g == 4) req = '0;
      end
      prev_busy = busy;
    end
    check("rr_grant_count", 32'(g), 32'd4);
    wait_idle();

    // Mid-frame reset, with a non-zero result and a non-default pattern beforehand
    run_frame(1, 16'hB6C0, 3, 0, 4'b0000, 0);
    cfg_idle(4'b0110);
    wait_idle();
    frameData = {NCH{16'h0000}};
    frameData[2*FL +: FL] = 16'hB0B0;
    req = 4'b0100;
    @(posedge clk); #1;
    req = '0;
    check("abort_gnt", 32'(gnt), 32'(4'b0100));
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_gnt_zero", 32'(gnt), 32'd0);
    check("abort_busy_zero", 32'(busy), 32'd0);
    check("abort_done_zero", 32'(done), 32'd0);
    check("abort_done_id_zero", 32'(doneId), 32'd0);
    check("abort_count_zero", 32'(matchCount), 32'd0);
    check("abort_cfg_err_zero", 32'(cfgErr), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_idle_after", 32'(busy), 32'd0);
    // Pattern back to 1011 after reset (0110 would give 0)
    run_frame(3, 16'h000B, 1, 0, 4'b0000, 0);

    repeat (3) @(posedge clk);
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
